// File: rtl/mcu_port_arbiter.sv
// Shares the DDR controller user_req port between the cache and the DMA engine.
// DMA has priority; the cache is served after at most DMA_STREAK_MAX DMA wins.
module mcu_port_arbiter #(
  parameter int unsigned DMA_STREAK_MAX = 4,
  parameter int unsigned ACK_TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        MCU_CLK,
  input  logic        RST,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        dma_mcu_access,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        user_req,
  output logic        user_req_we,
  output logic [31:0] user_req_address,
  output logic [31:0] user_req_datain,
  input  logic        user_req_ack,
  input  logic [31:0] user_req_dataout,
  output logic        err_timeout
);

  localparam int SW = $clog2(DMA_STREAK_MAX + 1);
  localparam int WW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [WW-1:0] wdog;

  logic        streak_full;
  logic        pick_d;
  logic        timeout;
  logic        done;
  logic [31:0] rdata;

  assign streak_full = streak == SW'(DMA_STREAK_MAX);
  assign pick_d      = d_req & ~(c_req & streak_full);
  assign timeout     = wdog == WW'(ACK_TIMEOUT);
  assign done        = (state != IDLE) & (user_req_ack | timeout);
  // A real ack wins over a coincident timeout.
  assign rdata       = user_req_ack ? user_req_dataout : ERR_DATA;

  assign c_ack   = (state == OWN_C) & done;
  assign d_ack   = (state == OWN_D) & done;
  assign c_rdata = rdata;
  assign d_rdata = rdata;

  // Gated by RST so the cache sees access=1 while held in reset.
  assign dma_mcu_access =
    ~((state == OWN_D) | (RST & (state == IDLE) & pick_d));

  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      state            <= IDLE;
      user_req         <= 1'b0;
      user_req_we      <= 1'b0;
      user_req_address <= '0;
      user_req_datain  <= '0;
      streak           <= '0;
      wdog             <= '0;
      err_timeout      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            state            <= OWN_D;
            user_req         <= 1'b1;
            user_req_we      <= d_we;
            user_req_address <= d_addr;
            user_req_datain  <= d_wdata;
            wdog             <= '0;
          end else if (c_req) begin
            state            <= OWN_C;
            user_req         <= 1'b1;
            user_req_we      <= c_we;
            user_req_address <= c_addr;
            user_req_datain  <= c_wdata;
            wdog             <= '0;
          end
        end
        OWN_C, OWN_D: begin
          if (done) begin
            state    <= IDLE;
            user_req <= 1'b0;
            if (!user_req_ack)
              err_timeout <= 1'b1;
            if (state == OWN_C || !c_req)
              streak <= '0;
            else if (!streak_full)
              streak <= streak + 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          user_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_port_arbiter.sv
// Directed bench for mcu_port_arbiter: single transactions, contention,
// watchdog, async reset and spurious acks.
module tb_mcu_port_arbiter;

  logic        MCU_CLK = 1'b0;
  logic        RST = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_ack;
  logic [31:0] c_rdata;
  logic        dma_mcu_access;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        user_req, user_req_we;
  logic [31:0] user_req_address, user_req_datain;
  logic        user_req_ack = 1'b0;
  logic [31:0] user_req_dataout = '0;
  logic        err_timeout;

  int checks = 0;
  int failures = 0;

  always #5 MCU_CLK = ~MCU_CLK;

  mcu_port_arbiter dut (
    .MCU_CLK(MCU_CLK), .RST(RST),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata), .dma_mcu_access(dma_mcu_access),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .user_req(user_req), .user_req_we(user_req_we),
    .user_req_address(user_req_address),
    .user_req_datain(user_req_datain),
    .user_req_ack(user_req_ack), .user_req_dataout(user_req_dataout),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge MCU_CLK);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int t;
    t = 0;
    while (!user_req && t < 20) begin
      step();
      t++;
    end
    if (!user_req) chk(tag, 32'd0, 32'd1);
  endtask

  logic order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int bad;
  logic owner_d;

  initial begin
    // reset values
    d_req = 1'b1;
    step();
    chk("rst_user_req", user_req, 0);
    chk("rst_access", dma_mcu_access, 1);
    chk("rst_acks", {c_ack, d_ack}, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_addr", user_req_address, 0);
    d_req = 1'b0;
    step();
    RST = 1'b1;
    step();

    // cache read alone, ack 6 cycles after request
    bad = 0;
    c_req = 1'b1; c_addr = 32'h0000_0040; c_we = 1'b0;
    #1;
    chk("rd_idle_user_req", user_req, 0);
    step();
    chk("rd_user_req", user_req, 1);
    chk("rd_addr", user_req_address, 32'h40);
    chk("rd_we", user_req_we, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (c_ack || d_ack || !user_req) bad++;
    end
    step();
    user_req_ack = 1'b1; user_req_dataout = 32'h5a5adada;
    #1;
    chk("rd_c_ack", c_ack, 1);
    chk("rd_c_rdata", c_rdata, 32'h5a5adada);
    if (d_ack) bad++;
    step();
    user_req_ack = 1'b0; c_req = 1'b0;
    #1;
    chk("rd_drop", user_req, 0);
    chk("rd_ack_pulse", c_ack, 0);
    if (d_ack) bad++;
    chk("rd_no_stray", bad, 0);

    // cache write, ack after 3 OWN cycles
    step();
    bad = 0;
    c_req = 1'b1; c_we = 1'b1;
    c_addr = 32'h10; c_wdata = 32'h1234_5678;
    step();
    chk("wr_addr", user_req_address, 32'h10);
    for (int i = 0; i < 3; i++) begin
      if (!user_req || !user_req_we ||
          user_req_datain != 32'h1234_5678) bad++;
      step();
    end
    user_req_ack = 1'b1;
    #1;
    if (!user_req_we || user_req_datain != 32'h1234_5678) bad++;
    chk("wr_c_ack", c_ack, 1);
    chk("wr_stable", bad, 0);
    step();
    user_req_ack = 1'b0; c_req = 1'b0; c_we = 1'b0;
    #1;
    chk("wr_drop", user_req, 0);
    step();

    // contention: both requesters held high
    c_addr = 32'hC0; d_addr = 32'hD0;
    c_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      step();
      wait_grant($sformatf("ct_wait%0d", g));
      chk($sformatf("ct_access%0d", g), dma_mcu_access, !order[g]);
      chk($sformatf("ct_addr%0d", g), user_req_address,
          order[g] ? 32'hD0 : 32'hC0);
      user_req_ack = 1'b1; user_req_dataout = 32'h100 + g;
      #1;
      owner_d = d_ack;
      chk($sformatf("ct_grant%0d", g), {c_ack, d_ack},
          order[g] ? 32'd1 : 32'd2);
      chk($sformatf("ct_owner%0d", g), owner_d, order[g]);
      step();
      user_req_ack = 1'b0;
    end
    c_req = 1'b0; d_req = 1'b0;
    step();
    step();

    // watchdog: DMA request never acked
    d_req = 1'b1; d_addr = 32'h300;
    step();
    chk("wd_entry", user_req, 1);
    chk("wd_access", dma_mcu_access, 0);
    bad = 0;
    for (int k = 1; k < 255; k++) begin
      step();
      if (d_ack || c_ack) bad++;
    end
    chk("wd_early", bad, 0);
    step();
    chk("wd_d_ack", d_ack, 1);
    chk("wd_rdata", d_rdata, 32'hDEADBEEF);
    step();
    d_req = 1'b0;
    #1;
    chk("wd_err", err_timeout, 1);
    chk("wd_drop", user_req, 0);
    chk("wd_ack_pulse", d_ack, 0);
    step();
    c_req = 1'b1; c_addr = 32'h44;
    step();
    chk("wd_c_grant", user_req_address, 32'h44);
    user_req_ack = 1'b1; user_req_dataout = 32'h0BAD_F00D;
    #1;
    chk("wd_c_ack", c_ack, 1);
    chk("wd_c_rdata", c_rdata, 32'h0BAD_F00D);
    step();
    user_req_ack = 1'b0; c_req = 1'b0;
    #1;
    chk("wd_err_sticky", err_timeout, 1);
    step();

    // spurious ack while idle
    user_req_ack = 1'b1;
    step();
    chk("sp_acks", {c_ack, d_ack}, 0);
    step();
    chk("sp_user_req", user_req, 0);
    chk("sp_access", dma_mcu_access, 1);
    user_req_ack = 1'b0;
    step();

    // async reset in the middle of OWN_C
    c_req = 1'b1; c_addr = 32'h80;
    step();
    chk("rs_own", user_req, 1);
    d_req = 1'b1; user_req_ack = 1'b1;
    #1;
    chk("rs_pre_ack", c_ack, 1);
    RST = 1'b0;
    #1;
    chk("rs_user_req", user_req, 0);
    chk("rs_c_ack", c_ack, 0);
    chk("rs_access", dma_mcu_access, 1);
    chk("rs_err_clr", err_timeout, 0);
    step();
    user_req_ack = 1'b0; d_req = 1'b0;
    RST = 1'b1;
    step();
    chk("rs_c_regrant", user_req, 1);
    chk("rs_c_addr", user_req_address, 32'h80);
    user_req_ack = 1'b1;
    #1;
    chk("rs_c_ack", c_ack, 1);
    step();
    user_req_ack = 1'b0; c_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=hang exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/mcu_port_arbiter.md
Name: mcu_port_arbiter

Overview:
- Sits between the two memory masters, snowball_cache (mem_* port) and the DMA engine, and the single user_req_* port of ddr_memory_controler.
- Runs entirely in the MCU clock domain.
- Grants the port to one master at a time and produces the cache's dma_mcu_access enable.
- Enforces DMA-priority arbitration with bounded cache starvation and an ack watchdog.

Parameters:
- DMA_STREAK_MAX, 4: consecutive DMA transactions allowed while the cache waits.
- ACK_TIMEOUT, 255: cycles in an OWN state without user_req_ack before a forced release.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timed-out transaction.

Ports:
- MCU_CLK  in  1  memory-side clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- c_req  in  1  cache mem_do_act.
- c_we  in  1  cache mem_we.
- c_addr  in  32  cache mem_addr.
- c_wdata  in  32  cache mem_dataintomem.
- c_ack  out  1  cache mem_ack.
- c_rdata  out  32  cache mem_datafrommem.
- dma_mcu_access  out  1  high = cache may issue; low = DMA owns or is about to own the port.
- d_req, d_we, d_addr[32], d_wdata[32]  in  DMA request, same meaning as c_*.
- d_ack  out  1  DMA ack.
- d_rdata  out  32  DMA read data.
- user_req  out  1  to controller.
- user_req_we  out  1  to controller.
- user_req_address  out  32  to controller.
- user_req_datain  out  32  to controller.
- user_req_ack  in  1  from controller.
- user_req_dataout  in  32  from controller.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (RST low, async) values:
  - state=IDLE.
  - user_req=0, user_req_we=0, user_req_address=0, user_req_datain=0.
  - c_ack=d_ack=0.
  - dma_mcu_access=1.
  - streak=0, wdog=0, err_timeout=0.
- Reset mid-transaction drops user_req immediately. The controller is reset by the same RST.
- Requester protocol:
  - Hold req, we, addr and wdata stable until ack.
  - Ack is a one-cycle pulse.
  - Drop req on the edge after ack; a new request may be raised one cycle later.
- States: IDLE, OWN_C, OWN_D.
- IDLE decision, evaluated each edge:
  - d_req & ~(c_req & streak==DMA_STREAK_MAX) -> OWN_D.
  - else c_req -> OWN_C.
  - else stay IDLE.
- Entering OWN_x:
  - Register the owner's we, addr and wdata onto user_req_*.
  - user_req=1 from the first OWN cycle, i.e. one cycle after req is sampled.
- OWN_x, user_req_ack=1:
  - Pulse x_ack combinationally in the same cycle.
  - x_rdata=user_req_dataout in that cycle.
  - Next edge: user_req=0, state=IDLE.
  - Non-owner ack stays 0; c_rdata/d_rdata are don't-care outside an ack cycle.
- Streak counter:
  - On OWN_D completion: streak=min(streak+1, DMA_STREAK_MAX).
  - On OWN_C completion: streak=0.
  - On OWN_D completion with c_req low: streak=0.
- dma_mcu_access = ~(state==OWN_D | (state==IDLE & d_req & ~(c_req & streak==DMA_STREAK_MAX))). Combinational; the cache must not start a new request while it is low.
- Watchdog:
  - wdog clears on entry to OWN and increments each OWN cycle without ack.
  - At wdog==ACK_TIMEOUT: pulse owner ack with rdata=ERR_DATA, set err_timeout, drop user_req, go to IDLE.
  - err_timeout clears only on reset.
- user_req_ack while IDLE is ignored; no state change.
- Simultaneous c_req and d_req with streak<MAX: DMA wins, and the cache request stays pending with no loss.
- Back-to-back: a requester may win the next IDLE decision two cycles after its ack at the earliest (ack cycle -> IDLE -> OWN).

Test Plan:
- Cache read alone: c_req=1, c_addr=32'h0000_0040; controller acks 6 cycles later with 32'h5a5adada -> user_req high 1 cycle after c_req, c_ack single pulse with c_rdata=32'h5a5adada, d_ack never asserts.
- Cache write: c_we=1, c_addr=32'h10, c_wdata=32'h1234_5678 -> user_req_we=1 and user_req_datain=32'h1234_5678 stable for the whole OWN_C, user_req=0 the cycle after ack.
- Contention: c_req and d_req held continuously, DMA_STREAK_MAX=4 -> grant order D,D,D,D,C,D,D,D,D,C; dma_mcu_access=0 during every OWN_D.
- Watchdog: d_req with the controller never acking, ACK_TIMEOUT=255 -> d_ack pulses 255 cycles after OWN_D entry with d_rdata=32'hDEADBEEF, err_timeout=1 and stays 1, next c_req serviced normally.
- Reset mid-OWN_C: RST low between edges -> user_req, c_ack=0 and dma_mcu_access=1 immediately without a clock; after release, state IDLE and streak=0.
- Spurious ack in IDLE: user_req_ack=1 with no requests -> no ack outputs, state stays IDLE.
